// File: rtl/tdm_mux41_enable.sv
// Time-division 4:1 serializer with active-low enable; snapshots d each frame and drives y/s.
// Optional even-parity fifth slot when TDM_PARITY_EN is defined.
module tdm_mux41_enable #(
    parameter int SLOT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic [3:0] d,
    output logic       y,
    output logic [1:0] s,
    output logic       frame,
    output logic       valid,
    output logic       ps
);
    localparam int DW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SLOT_CYCLES - 1);
`ifdef TDM_PARITY_EN
    localparam logic [2:0] LAST_SLOT = 3'd4;
`else
    localparam logic [2:0] LAST_SLOT = 3'd3;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [3:0]    shadow_q, shadow_d;
    logic [2:0]    slot_q, slot_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          y_d, frame_d, valid_d, ps_d;
    logic [1:0]    s_d;
    logic [2:0]    slot_inc;

    assign slot_inc = slot_q + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            slot_q   <= '0;
            dwell_q  <= '0;
            y        <= 1'b0;
            s        <= 2'd0;
            frame    <= 1'b0;
            valid    <= 1'b0;
            ps       <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            slot_q   <= slot_d;
            dwell_q  <= dwell_d;
            y        <= y_d;
            s        <= s_d;
            frame    <= frame_d;
            valid    <= valid_d;
            ps       <= ps_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        slot_d   = slot_q;
        dwell_d  = dwell_q;
        y_d      = y;
        s_d      = s;
        frame_d  = 1'b0;
        valid_d  = valid;
        ps_d     = ps;

        // Frame start: shared by IDLE->RUN entry and the wrap after the last slot.
        if (!e && (state_q == IDLE ||
                   (dwell_q == DWELL_LAST && slot_q == LAST_SLOT))) begin
            state_d  = RUN;
            shadow_d = d;
            slot_d   = 3'd0;
            dwell_d  = '0;
            y_d      = d[0];
            s_d      = 2'd0;
            frame_d  = 1'b1;
            valid_d  = 1'b1;
            ps_d     = 1'b0;
        end else if (e || state_q == IDLE) begin
            // Disabled: abandon any partial frame and park everything at reset values.
            state_d  = IDLE;
            shadow_d = '0;
            slot_d   = 3'd0;
            dwell_d  = '0;
            y_d      = 1'b0;
            s_d      = 2'd0;
            valid_d  = 1'b0;
            ps_d     = 1'b0;
        end else if (dwell_q != DWELL_LAST) begin
            dwell_d = dwell_q + DW'(1);
        end else begin
            dwell_d = '0;
            slot_d  = slot_inc;
`ifdef TDM_PARITY_EN
            if (slot_inc == 3'd4) begin
                y_d  = ^shadow_q;
                s_d  = 2'd3;
                ps_d = 1'b1;
            end else begin
                y_d = shadow_q[slot_inc[1:0]];
                s_d = slot_inc[1:0];
            end
`else
            y_d = shadow_q[slot_inc[1:0]];
            s_d = slot_inc[1:0];
`endif
        end
    end
endmodule

// File: tb/tb_tdm_mux41_enable.sv
// Directed bench for tdm_mux41_enable: SLOT_CYCLES=1 and SLOT_CYCLES=3 instances on shared inputs.
// Works with or without TDM_PARITY_EN defined.
module tb_tdm_mux41_enable;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       e = 1'b1;
    logic [3:0] d = 4'b0000;
    logic       y1, frame1, valid1, ps1;
    logic [1:0] s1;
    logic       y3, frame3, valid3, ps3;
    logic [1:0] s3;
    int total = 0;
    int bad = 0;

`ifdef TDM_PARITY_EN
    localparam int NSLOT = 5;
`else
    localparam int NSLOT = 4;
`endif

    always #5 clk = ~clk;

    tdm_mux41_enable #(.SLOT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .e(e), .d(d),
        .y(y1), .s(s1), .frame(frame1), .valid(valid1), .ps(ps1));
    tdm_mux41_enable #(.SLOT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .e(e), .d(d),
        .y(y3), .s(s3), .frame(frame3), .valid(valid3), .ps(ps3));

    // Reset for one edge, then release with e=0 so the next edge starts a frame.
    task automatic restart(input logic [3:0] dv);
        @(negedge clk);
        rst = 1'b1; e = 1'b0; d = dv;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; e = 1'b0; d = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({y1, s1, frame1, valid1, ps1} !== 6'b0 || {y3, s3, frame3, valid3, ps3} !== 6'b0) begin
                bad++;
                $display("FAIL reset cyc%0d: dut1 y,s,f,v,ps=%b dut3=%b want 000000", i,
                         {y1, s1, frame1, valid1, ps1}, {y3, s3, frame3, valid3, ps3});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({y1, s1, frame1, valid1} !== 5'b0_00_11) begin
            bad++;
            $display("FAIL reset_release: y,s,f,v=%b want 000 11", {y1, s1, frame1, valid1});
        end
    endtask

    task automatic test_basic;
        // d=1011: slots y=1,1,0,1; parity slot y=1 (three ones)
        logic [4:0] y_exp = 5'b1_1011;
        logic [9:0] s_exp = {2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        restart(4'b1011);
        for (int i = 0; i < 2 * NSLOT; i++) begin
            int k;
            k = i % NSLOT;
            total++;
            if (y1 !== y_exp[k] || s1 !== s_exp[2*k +: 2] || frame1 !== (k == 0) ||
                valid1 !== 1'b1 || ps1 !== (k == 4)) begin
                bad++;
                $display("FAIL basic cyc%0d: y=%b s=%0d f=%b v=%b ps=%b want y=%b s=%0d f=%b v=1 ps=%b",
                         i, y1, s1, frame1, valid1, ps1, y_exp[k], s_exp[2*k +: 2], k == 0, k == 4);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_dwell;
        // d=0110, 3 cycles per slot; parity slot y=0 (two ones)
        logic [4:0] y_exp = 5'b0_0110;
        int last_frame = -1;
        restart(4'b0110);
        for (int i = 0; i < 2 * 3 * NSLOT; i++) begin
            int k;
            k = (i / 3) % NSLOT;
            total++;
            if (y3 !== y_exp[k] || s3 !== ((k == 4) ? 2'd3 : 2'(k)) ||
                frame3 !== (i % (3 * NSLOT) == 0) || valid3 !== 1'b1 || ps3 !== (k == 4)) begin
                bad++;
                $display("FAIL dwell cyc%0d: y=%b s=%0d f=%b v=%b ps=%b want y=%b slot=%0d", i,
                         y3, s3, frame3, valid3, ps3, y_exp[k], k);
            end
            if (frame3 === 1'b1) begin
                if (last_frame >= 0) begin
                    total++;
                    if (i - last_frame != 3 * NSLOT) begin
                        bad++;
                        $display("FAIL dwell_period: got %0d want %0d", i - last_frame, 3 * NSLOT);
                    end
                end
                last_frame = i;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_snapshot;
        restart(4'b0000);
        for (int i = 0; i < 2 * NSLOT; i++) begin
            logic want;
            if (i == 1) d = 4'b1111;
            // Second frame: all ones in data slots, parity of 1111 is 0
            want = (i >= NSLOT) && (i - NSLOT < 4);
            total++;
            if (y1 !== want || frame1 !== (i % NSLOT == 0)) begin
                bad++;
                $display("FAIL snapshot cyc%0d: y=%b f=%b want y=%b", i, y1, frame1, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_disable;
        restart(4'b1011);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (s1 !== 2'd2) begin
            bad++;
            $display("FAIL disable_pre: s=%0d want 2", s1);
        end
        e = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({y1, s1, frame1, valid1, ps1} !== 6'b0) begin
                bad++;
                $display("FAIL disable_idle%0d: y,s,f,v,ps=%b want 000000", i, {y1, s1, frame1, valid1, ps1});
            end
        end
        e = 1'b0;
        @(negedge clk);
        total++;
        if ({y1, s1, frame1, valid1} !== 5'b1_00_11) begin
            bad++;
            $display("FAIL disable_restart: y,s,f,v=%b want 100 11", {y1, s1, frame1, valid1});
        end
    endtask

    task automatic test_toggle;
        // e alternating: each RUN cycle is a fresh frame start
        restart(4'b0101);
        for (int i = 0; i < 6; i++) begin
            logic run;
            e = (i % 2 == 0);
            @(negedge clk);
            run = (i % 2 == 1);
            total++;
            if (valid1 !== run || frame1 !== run || s1 !== 2'd0 || y1 !== run ||
                valid3 !== run || frame3 !== run) begin
                bad++;
                $display("FAIL toggle cyc%0d: v=%b f=%b s=%0d y=%b v3=%b f3=%b want run=%b",
                         i, valid1, frame1, s1, y1, valid3, frame3, run);
            end
        end
        e = 1'b0;
    endtask

`ifdef TDM_PARITY_EN
    task automatic test_parity;
        restart(4'b0111);
        repeat (4) @(negedge clk);
        total++;
        if (y1 !== 1'b1 || ps1 !== 1'b1 || s1 !== 2'd3 || valid1 !== 1'b1) begin
            bad++;
            $display("FAIL parity_0111: y=%b ps=%b s=%0d v=%b want 1 1 3 1", y1, ps1, s1, valid1);
        end
        @(negedge clk);
        total++;
        if (frame1 !== 1'b1 || ps1 !== 1'b0 || s1 !== 2'd0) begin
            bad++;
            $display("FAIL parity_wrap: f=%b ps=%b s=%0d want 1 0 0", frame1, ps1, s1);
        end
        restart(4'b0011);
        repeat (4) @(negedge clk);
        total++;
        if (y1 !== 1'b0 || ps1 !== 1'b1 || s1 !== 2'd3) begin
            bad++;
            $display("FAIL parity_0011: y=%b ps=%b s=%0d want 0 1 3", y1, ps1, s1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_dwell();
        test_snapshot();
        test_disable();
        test_toggle();
`ifdef TDM_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
